// File: rtl/demux16_1_wr_if.sv
// Write/clear handshake bundle between a requester and the demux16_1_wr
// register bank.
interface demux16_1_wr_if #(
    parameter int WIDTH = 16
);
    logic             wr_valid;
    logic             wr_ready;
    logic [3:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             clr_req;
    logic             busy;
    logic             wr_done;

    modport master (
        output wr_valid, wr_sel, wr_data, clr_req,
        input  wr_ready, busy, wr_done
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data, clr_req,
        output wr_ready, busy, wr_done
    );
endinterface

// File: rtl/demux16_1_wr.sv
// Sixteen-entry register bank written one entry at a time, with a
// sequential clear sweep; its outputs feed the inputs of a mux16_1.
module demux16_1_wr #(
    parameter int WIDTH = 16,
    parameter bit ZERO0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    demux16_1_wr_if.slave     bus,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [WIDTH-1:0]  out4,
    output logic [WIDTH-1:0]  out5,
    output logic [WIDTH-1:0]  out6,
    output logic [WIDTH-1:0]  out7,
    output logic [WIDTH-1:0]  out8,
    output logic [WIDTH-1:0]  out9,
    output logic [WIDTH-1:0]  out10,
    output logic [WIDTH-1:0]  out11,
    output logic [WIDTH-1:0]  out12,
    output logic [WIDTH-1:0]  out13,
    output logic [WIDTH-1:0]  out14,
    output logic [WIDTH-1:0]  out15
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       clr_idx_q, clr_idx_d;
    logic             done_q;
    logic             wr_fire;
    logic [WIDTH-1:0] regs_q [16];

    // Handshake outputs depend on the state register only, never on requests.
    assign bus.wr_ready = (state_q == IDLE);
    assign bus.busy     = (state_q == CLEAR);
    assign bus.wr_done  = done_q;

    assign wr_fire = bus.wr_valid && (state_q == IDLE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = 4'd0;
                end
            end
            CLEAR: begin
                clr_idx_d = clr_idx_q + 4'd1;
                if (clr_idx_q == 4'd15) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            clr_idx_q <= 4'd0;
            done_q    <= 1'b0;
            // NOTE: the register array is reset on purpose; its contents are architecturally visible as zero after reset.
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            done_q    <= wr_fire;
            if (wr_fire && !(ZERO0 && bus.wr_sel == 4'd0)) begin
                regs_q[bus.wr_sel] <= bus.wr_data;
            end
            // Writes are blocked in CLEAR, so the sweep never races a write.
            if (state_q == CLEAR) begin
                regs_q[clr_idx_q] <= '0;
            end
        end
    end

    assign out0  = ZERO0 ? '0 : regs_q[0];
    assign out1  = regs_q[1];
    assign out2  = regs_q[2];
    assign out3  = regs_q[3];
    assign out4  = regs_q[4];
    assign out5  = regs_q[5];
    assign out6  = regs_q[6];
    assign out7  = regs_q[7];
    assign out8  = regs_q[8];
    assign out9  = regs_q[9];
    assign out10 = regs_q[10];
    assign out11 = regs_q[11];
    assign out12 = regs_q[12];
    assign out13 = regs_q[13];
    assign out14 = regs_q[14];
    assign out15 = regs_q[15];

endmodule
